// File: rtl/shared_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Shared types and helpers for the shared bus arbiter: FSM state
//             enum, owner-id width helper and a popcount function.
//  Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Largest agent count supported. Also the fixed width of popcount's input.
  localparam int c_max_agents = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Owner-id width for n agents; at least 1 bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int popcount(input logic [c_max_agents-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < c_max_agents; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : shared_bus_arbiter_if
//  Purpose  : Agent-side request/data/enable signals and arbiter-side
//             grant/bus outputs of the shared bus.
//  Ports    : master - agents (drive req/din/drv_en/err_clr)
//             slave  - arbiter (drives gnt/owner_id/bus_data/bus_valid/
//                      contention)
//  Revision : 1.0 - initial release
// ============================================================================
interface shared_bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int c_id_w = id_w(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       drv_en;
  logic               err_clr;
  logic [N-1:0]       gnt;
  logic [c_id_w-1:0]  owner_id;
  logic [WIDTH-1:0]   bus_data;
  logic               bus_valid;
  logic               contention;

  modport master (
    output req, din, drv_en, err_clr,
    input  gnt, owner_id, bus_data, bus_valid, contention
  );

  modport slave (
    input  req, din, drv_en, err_clr,
    output gnt, owner_id, bus_data, bus_valid, contention
  );
endinterface
`default_nettype wire

// File: rtl/shared_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin selector. Searches req starting at
//             (last+1) mod N upward with wrap and returns the first requester.
//  Ports    : req    in  N     pending requests
//             last   in  ID_W  previous winner
//             onehot out N     one-hot winner (0 if no request)
//             id     out ID_W  winner index
//             any    out 1     a winner exists
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] id,
  output logic            any
);

  logic [ID_W-1:0] w_idx;

  // k runs 1..N so the previous winner is considered last.
  always_comb begin
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = ID_W'((int'(last) + k) % N);
      if (!any && req[w_idx]) begin
        any           = 1'b1;
        onehot[w_idx] = 1'b1;
        id            = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_bus_arbiter
//  Purpose  : Grants a shared WIDTH-bit bus to one of N agents at a time in
//             round-robin order, inserts a turnaround gap between owners,
//             drives registered owner data and flags drive contention.
//  Ports    : clk   in  rising-edge clock
//             rst_n in  asynchronous active-low reset
//             bus   slave modport: req/din/drv_en/err_clr in,
//                   gnt/owner_id/bus_data/bus_valid/contention out
//  Revision : 1.0 - initial release
// ============================================================================
module shared_bus_arbiter
  import bus_pkg::*;
#(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  shared_bus_arbiter_if.slave bus
);

  localparam int                 c_id_w      = id_w(N);
  localparam int                 c_hold_w    = $clog2(MAX_HOLD + 1);
  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);
  localparam logic [2:0]         c_turn_last = (TURN_CYC > 0) ? 3'(TURN_CYC - 1) : 3'd0;

  state_t              r_state, w_state_nxt;
  logic [N-1:0]        r_gnt, w_gnt_nxt;
  logic [c_id_w-1:0]   r_owner, w_owner_nxt;
  logic [c_id_w-1:0]   r_last, w_last_nxt;
  logic [c_hold_w-1:0] r_hold, w_hold_nxt;
  logic [2:0]          r_turn, w_turn_nxt;
  logic [WIDTH-1:0]    r_data, w_data_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_cont;

  logic [N-1:0]              w_pick;
  logic [c_id_w-1:0]         w_pick_id;
  logic                      w_pick_any;
  logic                      w_owner_req;
  logic                      w_others;
  logic                      w_viol;
  logic [c_max_agents-1:0]   w_drv_ext;

  rr_pick #(
    .N    (N),
    .ID_W (c_id_w)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (r_last),
    .onehot (w_pick),
    .id     (w_pick_id),
    .any    (w_pick_any)
  );

  assign w_owner_req = bus.req[r_owner];
  assign w_others    = |(bus.req & ~r_gnt);

  // Contention is judged against the grant currently on the outputs.
  assign w_drv_ext = c_max_agents'(bus.drv_en);
  assign w_viol    = (popcount(w_drv_ext) > 1) || (|(bus.drv_en & ~r_gnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= c_id_w'(N - 1);
      r_hold  <= '0;
      r_turn  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
      r_turn  <= w_turn_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_turn_nxt  = r_turn;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick;
          w_owner_nxt = w_pick_id;
          w_last_nxt  = w_pick_id;
          // The hold count includes the cycle that starts at this edge.
          w_hold_nxt  = c_hold_w'(1);
        end
      end
      GRANT: begin
        if (!w_owner_req || (r_hold == c_hold_max && w_others)) begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_data_nxt  = '0;
          w_turn_nxt  = c_turn_last;
          w_state_nxt = (TURN_CYC == 0) ? IDLE : TURN;
        end else begin
          w_data_nxt  = bus.din[int'(r_owner)*WIDTH +: WIDTH];
          w_valid_nxt = 1'b1;
          // Saturate so a lone owner keeps the bus indefinitely.
          if (r_hold != c_hold_max) w_hold_nxt = r_hold + 1'b1;
        end
      end
      TURN: begin
        if (r_turn == 3'd0) w_state_nxt = IDLE;
        else                w_turn_nxt  = r_turn - 3'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sticky flag: a new violation wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_cont <= 1'b0;
    else if (w_viol)      r_cont <= 1'b1;
    else if (bus.err_clr) r_cont <= 1'b0;
  end

  assign bus.gnt        = r_gnt;
  assign bus.owner_id   = r_owner;
  assign bus.bus_data   = r_data;
  assign bus.bus_valid  = r_valid;
  assign bus.contention = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_bus_arbiter
//  Purpose  : Self-checking bench for shared_bus_arbiter: directed scenarios
//             with literal expectations plus randomized traffic compared
//             every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shared_bus_arbiter;
  import bus_pkg::*;

  localparam int N        = 4;
  localparam int WIDTH    = 8;
  localparam int TURN_CYC = 1;
  localparam int MAX_HOLD = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  shared_bus_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus_if ();

  shared_bus_arbiter #(
    .N        (N),
    .WIDTH    (WIDTH),
    .TURN_CYC (TURN_CYC),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_owner = -1 means nobody owns the bus; m_gap counts edges still to wait
  // before the next arbitration; m_held counts cycles the owner has had.
  int               m_owner, m_last, m_gap, m_held;
  logic             m_valid, m_cont;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  logic [N-1:0]     m_g;
  logic             m_viol;

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_gap = 0; m_held = 0;
      m_valid = 1'b0; m_cont = 1'b0; m_data = '0; m_id = 0;
    end else begin
      m_g    = model_gnt();
      m_viol = ($countones(bus_if.drv_en) > 1) || ((bus_if.drv_en & ~m_g) != '0);
      if (m_viol) m_cont = 1'b1;
      else if (bus_if.err_clr) m_cont = 1'b0;
      if (m_owner >= 0) begin
        if (!bus_if.req[m_owner] ||
            (m_held >= MAX_HOLD && ((bus_if.req & ~m_g) != '0))) begin
          m_owner = -1; m_valid = 1'b0; m_data = '0; m_gap = TURN_CYC;
        end else begin
          m_valid = 1'b1;
          m_data  = bus_if.din[m_owner*WIDTH +: WIDTH];
          if (m_held < MAX_HOLD) m_held++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && bus_if.req[(m_last + k) % N]) m_owner = (m_last + k) % N;
        end
        if (m_owner >= 0) begin
          m_last = m_owner; m_id = m_owner; m_held = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      check("cyc_gnt", 32'(bus_if.gnt), 32'(model_gnt()));
      check("cyc_bus_valid", 32'(bus_if.bus_valid), 32'(m_valid));
      check("cyc_bus_data", 32'(bus_if.bus_data), 32'(m_data));
      if (m_valid) check("cyc_owner_id", 32'(bus_if.owner_id), 32'(m_id));
      check("cyc_contention", 32'(bus_if.contention), 32'(m_cont));
      check("cyc_gnt_onehot", 32'($countones(bus_if.gnt) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_gnt(input logic [N-1:0] want, input int budget, input string name);
    int k;
    k = 0;
    while (bus_if.gnt !== want && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(bus_if.gnt), 32'(want));
  endtask

  int cnt;
  int seq[5];
  int nseq;
  int exp6[5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] prev;

  initial begin
    bus_if.req = '0; bus_if.din = '0; bus_if.drv_en = '0; bus_if.err_clr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("reset_gnt", 32'(bus_if.gnt), 32'd0);
    check("reset_valid", 32'(bus_if.bus_valid), 32'd0);
    check("reset_data", 32'(bus_if.bus_data), 32'd0);
    check("reset_owner", 32'(bus_if.owner_id), 32'd0);
    check("reset_cont", 32'(bus_if.contention), 32'd0);

    // 1: grant, then asynchronous reset mid-grant with contention pending.
    bus_if.req = 4'b0001; bus_if.din = 32'h11223344;
    tick(1);
    check("t1_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.drv_en = 4'b0010;
    tick(1);
    bus_if.drv_en = '0;
    tick(2);
    check("t1_valid_mid", 32'(bus_if.bus_valid), 32'd1);
    check("t1_data_mid", 32'(bus_if.bus_data), 32'h44);
    check("t1_cont_mid", 32'(bus_if.contention), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_gnt", 32'(bus_if.gnt), 32'd0);
    check("t1_rst_valid", 32'(bus_if.bus_valid), 32'd0);
    check("t1_rst_data", 32'(bus_if.bus_data), 32'd0);
    check("t1_rst_cont", 32'(bus_if.contention), 32'd0);
    bus_if.req = '0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("t1_no_resume", 32'(bus_if.gnt), 32'd0);
    bus_if.req = 4'b0001;
    tick(1);
    check("t1_regrant", 32'(bus_if.gnt), 32'h1);
    bus_if.req = '0;
    tick(3);

    // 2: round robin from pointer N-1 and turnaround gap.
    reset_pulse();
    bus_if.req = 4'b1010;
    tick(1);
    check("t2_gnt1", 32'(bus_if.gnt), 32'h2);
    check("t2_model_gnt1", 32'(model_gnt()), 32'h2);
    bus_if.req = 4'b1000;
    tick(1);
    check("t2_release", 32'(bus_if.gnt), 32'h0);
    tick(1);
    check("t2_gap", 32'(bus_if.gnt), 32'h0);
    tick(1);
    check("t2_gnt3", 32'(bus_if.gnt), 32'h8);
    bus_if.req = '0;
    tick(3);

    // 3: registered owner data.
    bus_if.din = 32'h00A5_0000;
    bus_if.req = 4'b0100;
    tick(1);
    check("t3_gnt", 32'(bus_if.gnt), 32'h4);
    tick(1);
    check("t3_data", 32'(bus_if.bus_data), 32'hA5);
    check("t3_valid", 32'(bus_if.bus_valid), 32'd1);
    check("t3_owner", 32'(bus_if.owner_id), 32'd2);
    check("t3_model_data", 32'(m_data), 32'hA5);
    bus_if.req = '0;
    tick(1);
    check("t3_drop_valid", 32'(bus_if.bus_valid), 32'd0);
    check("t3_drop_data", 32'(bus_if.bus_data), 32'd0);
    tick(2);

    // 4: forced release after MAX_HOLD, then a solo owner keeps the bus.
    bus_if.req = 4'b0001;
    tick(1);
    check("t4_gnt0", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b1001;
    cnt = 1;
    tick(1);
    while (bus_if.gnt == 4'b0001 && cnt < 100) begin
      cnt++;
      tick(1);
    end
    check("t4_hold_cycles", 32'(cnt), 32'(MAX_HOLD));
    wait_gnt(4'b1000, 5, "t4_gnt3_after_turn");
    bus_if.req = 4'b1000;
    cnt = 0;
    repeat (40) begin
      tick(1);
      if (bus_if.gnt == 4'b1000) cnt++;
    end
    check("t4_solo_hold", 32'(cnt), 32'd40);
    bus_if.req = '0;
    tick(3);

    // 5: sticky contention, clear, set-wins-over-clear.
    bus_if.req = 4'b0001;
    wait_gnt(4'b0001, 6, "t5_gnt0");
    bus_if.drv_en = 4'b0011;
    tick(1);
    check("t5_cont_set", 32'(bus_if.contention), 32'd1);
    bus_if.drv_en = 4'b0001;
    tick(2);
    check("t5_cont_sticky", 32'(bus_if.contention), 32'd1);
    bus_if.err_clr = 1'b1;
    tick(1);
    check("t5_cont_clr", 32'(bus_if.contention), 32'd0);
    bus_if.drv_en = 4'b0011;
    tick(1);
    check("t5_set_wins", 32'(bus_if.contention), 32'd1);
    bus_if.drv_en = '0;
    tick(1);
    check("t5_clr_again", 32'(bus_if.contention), 32'd0);
    bus_if.err_clr = 1'b0;
    bus_if.drv_en = 4'b0001;
    tick(2);
    check("t5_legal_drive", 32'(bus_if.contention), 32'd0);
    bus_if.drv_en = '0;
    bus_if.req = '0;
    tick(3);

    // 6: all agents request continuously.
    reset_pulse();
    bus_if.req = 4'b1111;
    nseq = 0;
    prev = '0;
    for (int k = 0; k < 200 && nseq < 5; k++) begin
      tick(1);
      if (bus_if.gnt != '0 && prev == '0) begin
        for (int j = 0; j < N; j++) if (bus_if.gnt[j]) seq[nseq] = j;
        nseq++;
      end
      prev = bus_if.gnt;
    end
    check("t6_grant_count", 32'(nseq), 32'd5);
    for (int i = 0; i < 5; i++) check("t6_order", 32'(seq[i]), 32'(exp6[i]));
    bus_if.req = '0;
    tick(3);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus_if.req = 4'($urandom_range(0, 15));
      bus_if.din = $urandom;
      case ($urandom_range(0, 19))
        0, 1, 2: bus_if.drv_en = bus_if.gnt;
        3:       bus_if.drv_en = 4'($urandom_range(0, 15));
        default: bus_if.drv_en = '0;
      endcase
      bus_if.err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick(1);
    end
    rst_n = 1'b1;
    bus_if.req = '0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
